// File: rtl/sdram_init_seq.sv
// SDRAM power-up initialisation sequencer: power-up wait, PRECHARGE ALL, N AUTO REFRESH, MRS.
// Supports restart from PRECHARGE on reinit_req once the sequence has completed.
module sdram_init_seq #(
    parameter int       POWERUP_CYCLES = 20000,
    parameter int       T_RP           = 2,
    parameter int       T_RFC          = 7,
    parameter int       T_MRD          = 2,
    parameter int       REFRESH_NUM    = 2,
    parameter int       CAS_LAT        = 3,
    parameter int       BURST_TYPE     = 0,
    parameter logic [2:0] BURST_LEN    = 3'b111,
    parameter int       WR_BURST       = 0,
    parameter int       ADDR_W         = 13,
    parameter int       BA_W           = 2,
    parameter int       DQ_W           = 16,
    parameter int       DQM_W          = 2
) (
    input  logic              sysclk_100M,
    input  logic              rst_n,
    input  logic              reinit_req,
    output logic              sdram_clk,
    output logic              sdram_cke,
    output logic              sdram_cs_n,
    output logic              sdram_ras_n,
    output logic              sdram_cas_n,
    output logic              sdram_we_n,
    output logic [BA_W-1:0]   sdram_ba,
    output logic [DQM_W-1:0]  sdram_dqm,
    output logic [ADDR_W-1:0] sdram_addr,
    inout  wire  [DQ_W-1:0]   sdram_dq,
    output logic              init_end_flag
);

    typedef enum logic [2:0] {
        ST_POWERUP, ST_PRE, ST_WAIT_RP, ST_REF, ST_WAIT_RFC, ST_MRS, ST_WAIT_MRD, ST_DONE
    } state_t;

    localparam int PWR_W   = $clog2(POWERUP_CYCLES + 1);
    localparam int GAP_MAX = (T_RP > T_RFC) ? ((T_RP > T_MRD) ? T_RP : T_MRD)
                                            : ((T_RFC > T_MRD) ? T_RFC : T_MRD);
    localparam int GAP_W   = $clog2(GAP_MAX + 1);

    localparam logic [PWR_W-1:0] PWR_LAST = PWR_W'(POWERUP_CYCLES - 1);
    // Gap loads are one less than the spacing: the command cycle itself counts as one.
    localparam logic [GAP_W-1:0] RP_LOAD  = GAP_W'(T_RP - 1);
    localparam logic [GAP_W-1:0] RFC_LOAD = GAP_W'(T_RFC - 1);
    localparam logic [GAP_W-1:0] MRD_LOAD = GAP_W'(T_MRD - 1);
    localparam logic [3:0]       REF_TOTAL = 4'(REFRESH_NUM);

    localparam logic [3:0] CMD_NOP = 4'b0111;
    localparam logic [3:0] CMD_PRE = 4'b0010;
    localparam logic [3:0] CMD_REF = 4'b0001;
    localparam logic [3:0] CMD_MRS = 4'b0000;

    localparam logic [9:0] MODE_BITS = {1'(WR_BURST), 2'b00, 3'(CAS_LAT), 1'(BURST_TYPE), BURST_LEN};
    localparam logic [ADDR_W-1:0] MODE_ADDR = ADDR_W'(MODE_BITS);
    localparam logic [ADDR_W-1:0] PRE_ADDR  = ADDR_W'(11'h400);
    localparam logic [ADDR_W-1:0] ZERO_ADDR = {ADDR_W{1'b0}};

    state_t            state_q, state_d;
    logic [PWR_W-1:0]  pwr_cnt_q, pwr_cnt_d;
    logic [GAP_W-1:0]  gap_cnt_q, gap_cnt_d;
    logic [3:0]        ref_cnt_q, ref_cnt_d;
    logic [3:0]        cmd_q, cmd_d;
    logic [ADDR_W-1:0] addr_q, addr_d;
    logic              flag_q, flag_d;

    // Next-state, counter and registered-bus computation.
    always_comb begin
        state_d   = state_q;
        pwr_cnt_d = pwr_cnt_q;
        gap_cnt_d = gap_cnt_q;
        ref_cnt_d = ref_cnt_q;
        cmd_d     = CMD_NOP;
        addr_d    = ZERO_ADDR;
        flag_d    = flag_q;
        case (state_q)
            ST_POWERUP: begin
                if (pwr_cnt_q == PWR_LAST) begin
                    state_d   = ST_PRE;
                    cmd_d     = CMD_PRE;
                    addr_d    = PRE_ADDR;
                    gap_cnt_d = RP_LOAD;
                end else begin
                    pwr_cnt_d = pwr_cnt_q + PWR_W'(1);
                end
            end
            ST_PRE, ST_WAIT_RP: begin
                if (gap_cnt_q == {GAP_W{1'b0}}) begin
                    state_d   = ST_REF;
                    cmd_d     = CMD_REF;
                    ref_cnt_d = ref_cnt_q + 4'd1;
                    gap_cnt_d = RFC_LOAD;
                end else begin
                    state_d   = ST_WAIT_RP;
                    gap_cnt_d = gap_cnt_q - GAP_W'(1);
                end
            end
            ST_REF, ST_WAIT_RFC: begin
                if (gap_cnt_q != {GAP_W{1'b0}}) begin
                    state_d   = ST_WAIT_RFC;
                    gap_cnt_d = gap_cnt_q - GAP_W'(1);
                end else if (ref_cnt_q < REF_TOTAL) begin
                    state_d   = ST_REF;
                    cmd_d     = CMD_REF;
                    ref_cnt_d = ref_cnt_q + 4'd1;
                    gap_cnt_d = RFC_LOAD;
                end else begin
                    state_d   = ST_MRS;
                    cmd_d     = CMD_MRS;
                    addr_d    = MODE_ADDR;
                    gap_cnt_d = MRD_LOAD;
                end
            end
            ST_MRS, ST_WAIT_MRD: begin
                if (gap_cnt_q == {GAP_W{1'b0}}) begin
                    state_d = ST_DONE;
                    flag_d  = 1'b1;
                end else begin
                    state_d   = ST_WAIT_MRD;
                    gap_cnt_d = gap_cnt_q - GAP_W'(1);
                end
            end
            ST_DONE: begin
                // Restart skips the power-up wait and re-enters at PRECHARGE.
                if (reinit_req) begin
                    state_d   = ST_PRE;
                    cmd_d     = CMD_PRE;
                    addr_d    = PRE_ADDR;
                    gap_cnt_d = RP_LOAD;
                    ref_cnt_d = 4'd0;
                    flag_d    = 1'b0;
                end else begin
                    state_d = ST_DONE;
                end
            end
            default: begin
                state_d = ST_POWERUP;
            end
        endcase
    end

    // State, counters and SDRAM bus registers with asynchronous reset.
    always_ff @(posedge sysclk_100M or negedge rst_n) begin
        if (!rst_n) begin
            state_q   <= ST_POWERUP;
            pwr_cnt_q <= {PWR_W{1'b0}};
            gap_cnt_q <= {GAP_W{1'b0}};
            ref_cnt_q <= 4'd0;
            cmd_q     <= CMD_NOP;
            addr_q    <= ZERO_ADDR;
            flag_q    <= 1'b0;
        end else begin
            state_q   <= state_d;
            pwr_cnt_q <= pwr_cnt_d;
            gap_cnt_q <= gap_cnt_d;
            ref_cnt_q <= ref_cnt_d;
            cmd_q     <= cmd_d;
            addr_q    <= addr_d;
            flag_q    <= flag_d;
        end
    end

    assign {sdram_cs_n, sdram_ras_n, sdram_cas_n, sdram_we_n} = cmd_q;
    assign sdram_addr    = addr_q;
    assign init_end_flag = flag_q;
    assign sdram_clk     = ~sysclk_100M;
    assign sdram_cke     = 1'b1;
    assign sdram_ba      = {BA_W{1'b0}};
    assign sdram_dqm     = {DQM_W{1'b0}};
    assign sdram_dq      = {DQ_W{1'bz}};

endmodule

// File: tb/tb_sdram_init_seq.sv
// Bench for sdram_init_seq: two configurations checked every cycle against an offset-based
// command schedule model, with random reinit pulses, mid-sequence reset and pinned literals.
module tb_sdram_init_seq;

    logic sysclk_100M = 1'b0;
    logic rst_n       = 1'b0;
    logic reinit_req  = 1'b0;
    always #5 sysclk_100M = ~sysclk_100M;

    int checks   = 0;
    int failures = 0;

    logic a_clk, a_cke, a_cs, a_ras, a_cas, a_we, a_flag;
    logic [1:0]  a_ba, a_dqm;
    logic [12:0] a_addr;
    wire  [15:0] a_dq;
    logic b_clk, b_cke, b_cs, b_ras, b_cas, b_we, b_flag;
    logic [1:0]  b_ba, b_dqm;
    logic [12:0] b_addr;
    wire  [15:0] b_dq;

    sdram_init_seq u_a (
        .sysclk_100M(sysclk_100M), .rst_n(rst_n), .reinit_req(reinit_req),
        .sdram_clk(a_clk), .sdram_cke(a_cke), .sdram_cs_n(a_cs), .sdram_ras_n(a_ras),
        .sdram_cas_n(a_cas), .sdram_we_n(a_we), .sdram_ba(a_ba), .sdram_dqm(a_dqm),
        .sdram_addr(a_addr), .sdram_dq(a_dq), .init_end_flag(a_flag)
    );

    sdram_init_seq #(
        .POWERUP_CYCLES(10), .T_RP(1), .T_RFC(1), .T_MRD(1), .REFRESH_NUM(8),
        .CAS_LAT(2), .BURST_TYPE(1), .BURST_LEN(3'b011), .WR_BURST(1)
    ) u_b (
        .sysclk_100M(sysclk_100M), .rst_n(rst_n), .reinit_req(reinit_req),
        .sdram_clk(b_clk), .sdram_cke(b_cke), .sdram_cs_n(b_cs), .sdram_ras_n(b_ras),
        .sdram_cas_n(b_cas), .sdram_we_n(b_we), .sdram_ba(b_ba), .sdram_dqm(b_dqm),
        .sdram_addr(b_addr), .sdram_dq(b_dq), .init_end_flag(b_flag)
    );

    wire [3:0]  act_cmd  [2];
    wire [12:0] act_addr [2];
    wire        act_flag [2];
    wire [5:0]  act_misc [2];
    wire [15:0] act_dq   [2];
    assign act_cmd[0]  = {a_cs, a_ras, a_cas, a_we};
    assign act_cmd[1]  = {b_cs, b_ras, b_cas, b_we};
    assign act_addr[0] = a_addr;
    assign act_addr[1] = b_addr;
    assign act_flag[0] = a_flag;
    assign act_flag[1] = b_flag;
    assign act_misc[0] = {a_clk, a_cke, a_ba, a_dqm};
    assign act_misc[1] = {b_clk, b_cke, b_ba, b_dqm};
    assign act_dq[0]   = a_dq;
    assign act_dq[1]   = b_dq;

    localparam logic [3:0] NOP = 4'b0111;
    localparam logic [3:0] PRE = 4'b0010;
    localparam logic [3:0] REF = 4'b0001;
    localparam logic [3:0] MRS = 4'b0000;

    // Model: per-configuration timing, plus edge index e and the edge s[d] of the latest PRECHARGE.
    int m_p    [2] = '{20000, 10};
    int m_trp  [2] = '{2, 1};
    int m_trfc [2] = '{7, 1};
    int m_tmrd [2] = '{2, 1};
    int m_n    [2] = '{2, 8};
    logic [12:0] m_mode [2];
    int e;
    int s [2];
    int nonnop;
    bit count_nonnop;

    function automatic logic [3:0] exp_cmd(int d, int o);
        int last_ref;
        last_ref = m_trp[d] + (m_n[d] - 1) * m_trfc[d];
        if (o == 0) return PRE;
        if (o >= m_trp[d] && o <= last_ref && ((o - m_trp[d]) % m_trfc[d]) == 0) return REF;
        if (o == m_trp[d] + m_n[d] * m_trfc[d]) return MRS;
        return NOP;
    endfunction

    function automatic logic exp_flag(int d, int ee);
        return (ee >= 1) && ((ee - s[d]) >= m_trp[d] + m_n[d] * m_trfc[d] + m_tmrd[d]);
    endfunction

    task automatic chk(input string nm, input int d, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s dut%0d edge=%0d got=%h expected=%h", nm, d, e, act, exp);
        end
    endtask

    task automatic compare_all();
        logic [3:0]  c;
        logic [12:0] ad;
        logic        f;
        for (int d = 0; d < 2; d++) begin
            if (rst_n) begin
                c  = exp_cmd(d, e - s[d]);
                ad = (c == PRE) ? 13'h0400 : ((c == MRS) ? m_mode[d] : 13'h0000);
                f  = exp_flag(d, e);
            end else begin
                c  = NOP;
                ad = 13'h0000;
                f  = 1'b0;
            end
            chk("cmd", d, 32'(act_cmd[d]), 32'(c));
            chk("addr", d, 32'(act_addr[d]), 32'(ad));
            chk("init_end_flag", d, 32'(act_flag[d]), 32'(f));
            chk("clk_cke_ba_dqm", d, 32'(act_misc[d]), 32'({~sysclk_100M, 1'b1, 2'b00, 2'b00}));
            chk("dq_highz", d, {16'h0000, act_dq[d]}, {16'h0000, 16'hzzzz});
        end
        if (count_nonnop && act_cmd[0] !== NOP) nonnop++;
    endtask

    // One clock: drive request, let the edge happen, advance the model, compare.
    task automatic step(input logic rq);
        reinit_req = rq;
        @(posedge sysclk_100M);
        #1;
        if (rst_n) begin
            e++;
            for (int d = 0; d < 2; d++) begin
                if (rq && exp_flag(d, e - 1)) s[d] = e;
            end
        end
        compare_all();
        @(negedge sysclk_100M);
    endtask

    task automatic release_reset();
        rst_n = 1'b1;
        e     = 0;
        s[0]  = m_p[0];
        s[1]  = m_p[1];
    endtask

    function automatic logic rand_rq();
        return ($urandom_range(0, 15) == 0);
    endfunction

    initial begin
        int r;
        m_mode[0] = {3'b000, 1'b0, 2'b00, 3'd3, 1'b0, 3'b111};
        m_mode[1] = {3'b000, 1'b1, 2'b00, 3'd2, 1'b1, 3'b011};
        e = 0; s[0] = m_p[0]; s[1] = m_p[1];
        nonnop = 0; count_nonnop = 1'b0;

        @(negedge sysclk_100M);
        step(1'b0);
        step(1'b0);
        release_reset();

        // Full default run; random pulses before completion must be ignored.
        count_nonnop = 1'b1;
        while (e < 20030) begin
            step((e < 20010) ? rand_rq() : 1'b0);
            if (e == 10)    chk("b_pre_lit", 1, 32'({act_cmd[1], act_addr[1]}), 32'({PRE, 13'h0400}));
            if (e >= 11 && e <= 18) chk("b_ref_lit", 1, 32'(act_cmd[1]), 32'(REF));
            if (e == 19)    chk("b_mrs_lit", 1, 32'({act_cmd[1], act_addr[1]}), 32'({MRS, 13'h022B}));
            if (e == 20)    chk("b_flag_lit", 1, 32'(act_flag[1]), 32'd1);
            if (e == 20000) chk("a_pre_lit", 0, 32'({act_cmd[0], act_addr[0]}), 32'({PRE, 13'h0400}));
            if (e == 20002 || e == 20009) chk("a_ref_lit", 0, 32'(act_cmd[0]), 32'(REF));
            if (e == 20016) chk("a_mrs_lit", 0, 32'({act_cmd[0], act_addr[0]}), 32'({MRS, 13'h0037}));
            if (e == 20017) chk("a_flag_early", 0, 32'(act_flag[0]), 32'd0);
            if (e == 20018) chk("a_flag_lit", 0, 32'(act_flag[0]), 32'd1);
        end
        count_nonnop = 1'b0;
        chk("a_nonnop_count", 0, 32'(nonnop), 32'd4);

        // Deterministic reinit, with an extra pulse landing in the refresh wait.
        step(1'b1);
        r = e;
        chk("reinit_flag_drop", 0, 32'({act_flag[0], act_cmd[0]}), 32'({1'b0, PRE}));
        for (int i = 1; i <= 20; i++) begin
            step(i == 5);
            if (e == r + 2 || e == r + 9) chk("reinit_ref_lit", 0, 32'(act_cmd[0]), 32'(REF));
            if (e == r + 16) chk("reinit_mrs_lit", 0, 32'({act_cmd[0], act_addr[0]}), 32'({MRS, 13'h0037}));
            if (e == r + 17) chk("reinit_flag_early", 0, 32'(act_flag[0]), 32'd0);
            if (e == r + 18) chk("reinit_flag_lit", 0, 32'(act_flag[0]), 32'd1);
        end

        for (int i = 0; i < 400; i++) step(rand_rq());

        // Fresh start, then reset asserted between the two refreshes.
        rst_n = 1'b0;
        step(1'b0);
        release_reset();
        while (e < 20005) step((e < 19990) ? rand_rq() : 1'b0);
        rst_n = 1'b0;
        #1;
        chk("async_rst_cmd", 0, 32'(act_cmd[0]), 32'(NOP));
        chk("async_rst_addr", 0, 32'(act_addr[0]), 32'd0);
        chk("async_rst_flag", 1, 32'(act_flag[1]), 32'd0);
        @(negedge sysclk_100M);
        e = 0;
        step(1'b0);
        step(1'b0);
        release_reset();
        while (e < 20020) begin
            step(1'b0);
            if (e == 19999) chk("rst_pre_not_early", 0, 32'(act_cmd[0]), 32'(NOP));
            if (e == 20000) chk("rst_pre_again", 0, 32'({act_cmd[0], act_addr[0]}), 32'({PRE, 13'h0400}));
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/sdram_init_seq.md
# sdram_init_seq

Parametrised SDRAM power-up initialisation sequencer, the successor of the fixed 13-step initialiser. It sits between the system clock/reset and the SDRAM pins during bring-up and drives the JEDEC sequence: power-up wait, PRECHARGE ALL, N AUTO REFRESH, then MODE REGISTER SET. Timing gaps, refresh count and mode-register fields are parameters. A re-initialisation request can restart the sequence after completion without a reset.

## Interface
- POWERUP_CYCLES, 20000: NOP cycles before PRECHARGE (≥1; 200 µs at 100 MHz)
- T_RP, 2: cycles from PRECHARGE to next command (≥1)
- T_RFC, 7: cycles from each REFRESH to next command (≥1)
- T_MRD, 2: cycles from MRS to init_end_flag (≥1)
- REFRESH_NUM, 2: AUTO REFRESH commands issued (1..15)
- CAS_LAT, 3: mode A6:A4 (2 or 3)
- BURST_TYPE, 0: mode A3 (0 sequential, 1 interleaved)
- BURST_LEN, 3'b111: mode A2:A0 code (111 = full page)
- WR_BURST, 0: mode A9 (0 burst write, 1 single write)
- ADDR_W, 13 / BA_W, 2 / DQ_W, 16 / DQM_W, 2: pin widths (ADDR_W ≥ 11)

Ports:
- sysclk_100M  in  1  system clock; all logic on rising edge
- rst_n  in  1  asynchronous active-low reset
- reinit_req  in  1  restart request; honoured only while init_end_flag=1
- sdram_clk  out  1  ~sysclk_100M
- sdram_cke  out  1  constant 1
- sdram_cs_n / sdram_ras_n / sdram_cas_n / sdram_we_n  out  1 each  registered command
- sdram_ba  out  BA_W  constant 0
- sdram_dqm  out  DQM_W  constant 0
- sdram_addr  out  ADDR_W  registered address
- sdram_dq  inout  DQ_W  always high-Z
- init_end_flag  out  1  registered; 1 = sequence complete, SDRAM usable

## Operation
- Commands {cs_n,ras_n,cas_n,we_n}: NOP 0111, PRECHARGE 0010, REFRESH 0001, MRS 0000.
- FSM states: POWERUP → PRE → WAIT_RP → REF → WAIT_RFC → (REF if refreshes issued < REFRESH_NUM, else MRS) → WAIT_MRD → DONE.
- Each command lasts exactly one cycle on the bus. All other cycles are NOP.
- sdram_addr values:
  - During PRECHARGE: A10=1, all other bits 0.
  - During MRS: {zeros, WR_BURST, 2'b00, CAS_LAT[2:0], BURST_TYPE, BURST_LEN[2:0]}.
  - Otherwise: 0.
  - Default MRS value is 13'h0037.
- Counters:
  - Power-up counter width is clog2(POWERUP_CYCLES+1). It saturates and never wraps.
  - Gap counter is sized for max(T_RP, T_RFC, T_MRD).
  - Refresh counter is 4 bits.
- DONE is terminal. The bus holds NOP, addr 0 and init_end_flag=1 until reset or reinit_req.
- reinit_req=1 sampled in DONE:
  - init_end_flag drops and PRECHARGE is issued at the same edge.
  - The power-up wait is skipped and the sequence continues from PRE onward.
- reinit_req in any other state is ignored and is not queued.
- Asserting rst_n low at any point:
  - Outputs return to reset values immediately (asynchronous).
  - On release the sequence restarts at POWERUP with a full wait.

## Timing
- Reset values: command NOP (0111), sdram_addr 0, init_end_flag 0, FSM POWERUP, all counters 0.
- Edge numbering: edge 1 is the first rising edge after rst_n release. P = POWERUP_CYCLES. A command registered at edge k is on the pins from edge k to edge k+1.
- PRECHARGE: edge P.
- REFRESH #i (i = 1..REFRESH_NUM): edge P + T_RP + (i−1)·T_RFC.
- MRS: edge P + T_RP + REFRESH_NUM·T_RFC.
- init_end_flag = 1: edge P + T_RP + REFRESH_NUM·T_RFC + T_MRD.
- Defaults: PRE 20000, REF 20002 and 20009, MRS 20016, flag 20018.
- Reinit with request sampled at edge r: PRE at r, REF at r+T_RP, and so on, per the same formulas with P replaced by r.
- Gaps of 1 (T_x=1) mean back-to-back commands with no NOP between them; this must be supported.

## Test plan
- Defaults, reset released at t0:
  - PRE with addr=0x400 at edge 20000.
  - REF at 20002 and 20009.
  - MRS with addr=0x0037 at 20016.
  - init_end_flag=1 at 20018.
  - Exactly 4 non-NOP cycles total.
- POWERUP_CYCLES=10, T_RP=1, T_RFC=1, T_MRD=1, REFRESH_NUM=8:
  - PRE at 10, then REF on 11–18 back-to-back.
  - MRS at 19, flag at 20.
- CAS_LAT=2, BURST_TYPE=1, BURST_LEN=3'b011, WR_BURST=1: MRS addr=0x022B.
- Reinit with defaults:
  - reinit_req pulsed at edge r after done: flag=0 and PRE at r, REF at r+2 and r+9, MRS at r+16, flag=1 at r+18.
  - A reinit_req pulse during WAIT_RFC causes no change in the sequence.
- rst_n low at edge 20005 (between the two refreshes):
  - Outputs go to NOP, addr 0 and flag 0 immediately.
  - After release, PRE comes again 20000 edges later.
- Throughout all runs:
  - sdram_dq stays Z.
  - sdram_cke=1, ba=0 and dqm=0.
  - sdram_clk is the inverse of sysclk_100M.
